// File: rtl/volume_meter_pkg.sv
// volume_meter_pkg: shared FSM states, level count and thermometer encoder
package volume_meter_pkg;
  typedef enum logic [1:0] {ACCUM, EVAL, UPDATE} vm_state_t;
  localparam int NUM_LEVELS = 16;
  function automatic logic [NUM_LEVELS-1:0] thermometer(input logic [4:0] lvl);
    logic [NUM_LEVELS-1:0] t;
    for (int i = 0; i < NUM_LEVELS; i++) t[i] = i < int'(lvl);
    return t;
  endfunction
endpackage

// File: rtl/vm_peak_window.sv
// vm_peak_window: per-window peak amplitude tracker around the silence baseline
module vm_peak_window #(
  parameter int SAMPLE_W = 12,
  parameter int WINDOW   = 4000,
  parameter int BASELINE = 2048
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] mic_in,
  output logic                window_done,
  output logic [SAMPLE_W-1:0] eval_peak
);
  localparam int CNT_W = $clog2(WINDOW);
  localparam logic [SAMPLE_W-1:0] BASE = SAMPLE_W'(BASELINE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);
  logic [SAMPLE_W-1:0] amp, peak, peak_next;
  logic [CNT_W-1:0] sample_cnt;
  // amplitude, running max including this sample, and window-close detect
  always_comb begin
    amp = mic_in >= BASE ? mic_in - BASE : BASE - mic_in;
    peak_next = amp > peak ? amp : peak;
    window_done = sample_valid && sample_cnt == LAST;
  end
  // closing sample is folded into eval_peak while the next window starts clean
  always_ff @(posedge clock) begin
    if (reset) begin
      peak <= '0;
      sample_cnt <= '0;
      eval_peak <= '0;
    end else if (window_done) begin
      eval_peak <= peak_next;
      peak <= '0;
      sample_cnt <= '0;
    end else if (sample_valid) begin
      peak <= peak_next;
      sample_cnt <= sample_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/volume_meter.sv
// volume_meter: windowed peak meter driving a 0..16 level and LED thermometer
module volume_meter
  import volume_meter_pkg::*;
#(
  parameter int SAMPLE_W = 12,
  parameter int WINDOW   = 4000,
  parameter int BASELINE = 2048,
  parameter int STEP     = 128,
  parameter int DECAY    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   mic_in,
  input  logic                  freeze,
  output logic [NUM_LEVELS-1:0] led_light,
  output logic [4:0]            level,
  output logic                  level_valid
);
  localparam int CW = SAMPLE_W + 5;
  vm_state_t state;
  logic window_done, hit;
  logic [SAMPLE_W-1:0] eval_peak;
  logic [3:0] k;
  logic [4:0] raw_level, dec_level, next_level;
  if (WINDOW < 32) begin : g_window_check
    $error("volume_meter: WINDOW must be >= 32 so a window cannot close during evaluation");
  end
  vm_peak_window #(
    .SAMPLE_W(SAMPLE_W),
    .WINDOW  (WINDOW),
    .BASELINE(BASELINE)
  ) u_peak (
    .clock       (clock),
    .reset       (reset),
    .sample_valid(sample_valid),
    .mic_in      (mic_in),
    .window_done (window_done),
    .eval_peak   (eval_peak)
  );
  // threshold test for step k and decay-limited candidate level
  always_comb begin
    hit = CW'(eval_peak) >= CW'((int'(k) + 1) * STEP);
    dec_level = int'(level) > DECAY ? 5'(int'(level) - DECAY) : 5'd0;
    next_level = (DECAY == 0 || raw_level >= level) ? raw_level
               : (raw_level > dec_level ? raw_level : dec_level);
  end
  // evaluator: 16 serial threshold compares, then one update cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ACCUM;
      k <= '0;
      raw_level <= '0;
      level <= '0;
      led_light <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      case (state)
        ACCUM: if (window_done) begin
          state <= EVAL;
          k <= '0;
          raw_level <= '0;
        end
        EVAL: begin
          raw_level <= raw_level + 5'(hit);
          k <= k + 4'd1;
          if (k == 4'd15) state <= UPDATE;
        end
        UPDATE: begin
          state <= ACCUM;
          if (!freeze) begin
            level <= next_level;
            led_light <= thermometer(next_level);
            level_valid <= 1'b1;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
